// File: rtl/cv32e40p_alu_div_seq.sv
////////////////////////////////////////////////////////////////////////////////
// Module  : cv32e40p_alu_div_seq
// Purpose : Request/response sequencer around the serial divider. Accepts one
//           div/rem request and computes the divider's operand prep: the
//           divisor normalisation shift and the zero and sign flags. It then
//           issues the request, waits for completion, captures the result and
//           returns it on a valid/ready response port. Divide-by-zero and
//           signed overflow (MIN / -1) are resolved locally and never reach
//           the divider.
//
// Ports   :
//   Clk_CI           clock
//   Rst_RI           synchronous active-high reset (also resets the divider)
//   ReqVld_SI        request valid
//   ReqRdy_SO        request ready, high only in IDLE
//   ReqOpA_DI        dividend
//   ReqOpB_DI        divisor
//   ReqOpCode_SI     0 udiv, 1 div, 2 urem, 3 rem
//   RspVld_SO        result valid
//   RspRdy_SI        result ready
//   RspRes_DO        result
//   DivOpA_DO        divider OpA_DI
//   DivOpB_DO        divider OpB_DI, divisor pre-shifted by DivOpBShift_DO
//   DivOpBShift_DO   divider OpBShift_DI
//   DivOpBIsZero_SO  divider OpBIsZero_SI
//   DivOpBSign_SO    divider OpBSign_SI, 0 for unsigned operations
//   DivOpCode_SO     divider OpCode_SI
//   DivInVld_SO      divider InVld_SI
//   DivOutRdy_SO     divider OutRdy_SI
//   DivOutVld_SI     divider OutVld_SO
//   DivRes_DI        divider Res_DO
////////////////////////////////////////////////////////////////////////////////

module cv32e40p_alu_div_seq #(
   parameter int C_WIDTH     = 32,
   parameter int C_LOG_WIDTH = 6
) (
   input  logic                   Clk_CI,
   input  logic                   Rst_RI,

   // request port
   input  logic                   ReqVld_SI,
   output logic                   ReqRdy_SO,
   input  logic [C_WIDTH-1:0]     ReqOpA_DI,
   input  logic [C_WIDTH-1:0]     ReqOpB_DI,
   input  logic [1:0]             ReqOpCode_SI,

   // response port
   output logic                   RspVld_SO,
   input  logic                   RspRdy_SI,
   output logic [C_WIDTH-1:0]     RspRes_DO,

   // serial divider interface
   output logic [C_WIDTH-1:0]     DivOpA_DO,
   output logic [C_WIDTH-1:0]     DivOpB_DO,
   output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
   output logic                   DivOpBIsZero_SO,
   output logic                   DivOpBSign_SO,
   output logic [1:0]             DivOpCode_SO,
   output logic                   DivInVld_SO,
   output logic                   DivOutRdy_SO,
   input  logic                   DivOutVld_SI,
   input  logic [C_WIDTH-1:0]     DivRes_DI
);

   localparam logic [C_WIDTH-1:0] MIN_VAL = {1'b1, {(C_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ISSUE,
      WAIT_DIV,
      RESP
   } state_t;

   state_t                 state_SP;

   logic [C_WIDTH-1:0]     opA_DP;
   logic [C_WIDTH-1:0]     opB_DP;
   logic [1:0]             opCode_SP;

   logic [C_WIDTH-1:0]     divOpB_DP;
   logic [C_LOG_WIDTH-1:0] divOpBShift_DP;
   logic                   divOpBIsZero_SP;
   logic                   divOpBSign_SP;
   logic                   divInVld_SP;
   logic                   waitFirst_SP;
   logic [C_WIDTH-1:0]     res_DP;

   logic                   sgn_S;
   logic                   bSign_S;
   logic                   bIsZero_S;
   logic                   ovf_S;
   logic [C_WIDTH-1:0]     bMag_D;
   logic [C_LOG_WIDTH-1:0] bShift_D;
   logic [C_WIDTH-1:0]     fastRes_D;

   // Leading-zero count over C_WIDTH bits; an all-zero input yields 0 so the
   // divide-by-zero case never produces an out-of-range shift.
   function automatic logic [C_LOG_WIDTH-1:0] clz(input logic [C_WIDTH-1:0] v);
      logic [C_WIDTH-1:0] t;
      logic               found;
      int                 cnt;
      t     = v;
      found = 1'b0;
      cnt   = 0;
      for (int i = 0; i < C_WIDTH; i++) begin
         if (!found) begin
            if (t[C_WIDTH-1]) found = 1'b1;
            else              cnt   = cnt + 1;
         end
         t = t << 1;
      end
      if (!found) cnt = 0;
      return C_LOG_WIDTH'(cnt);
   endfunction

   //---------------------------------------------------------------------------
   // Operand prep, evaluated from the latched request while in PREP
   //---------------------------------------------------------------------------
   // NOTE: every signal written in an always_comb gets a default first, so no
   //       path through the block can leave it unassigned and infer a latch.
   always_comb begin
      fastRes_D = '0;

      sgn_S     = opCode_SP[0];
      bSign_S   = sgn_S & opB_DP[C_WIDTH-1];
      // The divider works on the magnitude; a negative divisor is normalised
      // by the leading zeros of its absolute value.
      bMag_D    = bSign_S ? (-opB_DP) : opB_DP;
      bShift_D  = clz(bMag_D);
      bIsZero_S = (opB_DP == '0);
      ovf_S     = sgn_S & (opA_DP == MIN_VAL) & (opB_DP == '1);

      // RISC-V defined results for the two cases that bypass the divider.
      if (bIsZero_S) begin
         fastRes_D = opCode_SP[1] ? opA_DP : '1;
      end else if (ovf_S) begin
         fastRes_D = opCode_SP[1] ? '0 : MIN_VAL;
      end
   end

   //---------------------------------------------------------------------------
   // Sequencer FSM with its registered outputs
   //---------------------------------------------------------------------------
   // NOTE: all state in this always_ff uses non-blocking assignments so every
   //       register samples the values from before the clock edge.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state_SP        <= IDLE;
         opA_DP          <= '0;
         opB_DP          <= '0;
         opCode_SP       <= '0;
         divOpB_DP       <= '0;
         divOpBShift_DP  <= '0;
         divOpBIsZero_SP <= 1'b0;
         divOpBSign_SP   <= 1'b0;
         divInVld_SP     <= 1'b0;
         waitFirst_SP    <= 1'b0;
         res_DP          <= '0;
      end else begin
         unique case (state_SP)
            IDLE: begin
               if (ReqVld_SI) begin
                  opA_DP    <= ReqOpA_DI;
                  opB_DP    <= ReqOpB_DI;
                  opCode_SP <= ReqOpCode_SI;
                  state_SP  <= PREP;
               end
            end

            PREP: begin
               // Shift wraps intentionally: for a negative divisor the bits
               // shifted out are copies of the sign.
               divOpB_DP       <= opB_DP << bShift_D;
               divOpBShift_DP  <= bShift_D;
               divOpBIsZero_SP <= bIsZero_S;
               divOpBSign_SP   <= bSign_S;
               if (bIsZero_S || ovf_S) begin
                  res_DP   <= fastRes_D;
                  state_SP <= RESP;
               end else begin
                  divInVld_SP <= 1'b1;
                  state_SP    <= ISSUE;
               end
            end

            ISSUE: begin
               // Divider is guaranteed idle: every earlier result was drained
               // before this request could be accepted.
               divInVld_SP  <= 1'b0;
               waitFirst_SP <= 1'b1;
               state_SP     <= WAIT_DIV;
            end

            WAIT_DIV: begin
               // The divider's valid is not trusted in the cycle right after
               // issue; it may still reflect its pre-issue state.
               if (waitFirst_SP) begin
                  waitFirst_SP <= 1'b0;
               end else if (DivOutVld_SI) begin
                  res_DP   <= DivRes_DI;
                  state_SP <= RESP;
               end
            end

            RESP: begin
               if (RspRdy_SI) state_SP <= IDLE;
            end

            default: state_SP <= IDLE;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign ReqRdy_SO       = (state_SP == IDLE);
   assign RspVld_SO       = (state_SP == RESP);
   assign DivOutRdy_SO    = (state_SP == WAIT_DIV) & ~waitFirst_SP;

   assign RspRes_DO       = res_DP;
   assign DivOpA_DO       = opA_DP;
   assign DivOpB_DO       = divOpB_DP;
   assign DivOpBShift_DO  = divOpBShift_DP;
   assign DivOpBIsZero_SO = divOpBIsZero_SP;
   assign DivOpBSign_SO   = divOpBSign_SP;
   assign DivOpCode_SO    = opCode_SP;
   assign DivInVld_SO     = divInVld_SP;

endmodule
